// File: rtl/timer_counter.sv
// 8-bit up/down timer stage with parallel load, wrap pulses and sticky wrap flags.
// Optional compare-match output is compiled in when macro TMR_CMP_EN is defined.
module timer_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_ena,
   input  logic             count_en,
   input  logic             count_dir,
   input  logic             load,
   input  logic [WIDTH-1:0] tdr,
   input  logic             ovf_clr,
   input  logic             udf_clr,
`ifdef TMR_CMP_EN
   input  logic [WIDTH-1:0] cmp_val,
   output logic             cmp_match,
`endif
   output logic [WIDTH-1:0] tcnt,
   output logic             ovf_pulse,
   output logic             udf_pulse,
   output logic             ovf_flag,
   output logic             udf_flag
);

   localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ALL_ONE  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   logic             tick_s;
   logic [WIDTH-1:0] tcnt_nxt_s;
   logic             ovf_nxt_s;
   logic             udf_nxt_s;
   logic             ovf_flag_nxt_s;
   logic             udf_flag_nxt_s;

   logic [WIDTH-1:0] tcnt_r;
   logic             ovf_pulse_r;
   logic             udf_pulse_r;
   logic             ovf_flag_r;
   logic             udf_flag_r;

   assign tick_s = clk_ena & count_en & ~load;

   // Next counter value and wrap detection; load beats tick, and a load never pulses.
   always_comb begin
      tcnt_nxt_s = tcnt_r;
      ovf_nxt_s  = 1'b0;
      udf_nxt_s  = 1'b0;
      if (load) begin
         tcnt_nxt_s = tdr;
      end else if (tick_s) begin
         if (count_dir) begin
            tcnt_nxt_s = tcnt_r - ONE;
            udf_nxt_s  = (tcnt_r == ALL_ZERO);
         end else begin
            tcnt_nxt_s = tcnt_r + ONE;
            ovf_nxt_s  = (tcnt_r == ALL_ONE);
         end
      end else begin
         tcnt_nxt_s = tcnt_r;
      end
   end

   // Sticky flags: a new wrap overrides a coincident clear.
   always_comb begin
      ovf_flag_nxt_s = ovf_nxt_s | (ovf_flag_r & ~ovf_clr);
      udf_flag_nxt_s = udf_nxt_s | (udf_flag_r & ~udf_clr);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt_r      <= ALL_ZERO;
         ovf_pulse_r <= 1'b0;
         udf_pulse_r <= 1'b0;
         ovf_flag_r  <= 1'b0;
         udf_flag_r  <= 1'b0;
      end else begin
         tcnt_r      <= tcnt_nxt_s;
         ovf_pulse_r <= ovf_nxt_s;
         udf_pulse_r <= udf_nxt_s;
         ovf_flag_r  <= ovf_flag_nxt_s;
         udf_flag_r  <= udf_flag_nxt_s;
      end
   end

   assign tcnt      = tcnt_r;
   assign ovf_pulse = ovf_pulse_r;
   assign udf_pulse = udf_pulse_r;
   assign ovf_flag  = ovf_flag_r;
   assign udf_flag  = udf_flag_r;

`ifdef TMR_CMP_EN
   logic cmp_nxt_s;
   logic cmp_match_r;

   // Only a tick landing on the compare value matches; loads and holds do not.
   always_comb begin
      if (tick_s) begin
         cmp_nxt_s = (tcnt_nxt_s == cmp_val);
      end else begin
         cmp_nxt_s = 1'b0;
      end
   end

   // Compare-match pulse register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmp_match_r <= 1'b0;
      end else begin
         cmp_match_r <= cmp_nxt_s;
      end
   end

   assign cmp_match = cmp_match_r;
`endif

endmodule
